// File: rtl/stepper_phase_pkg.sv
// stepper_phase_pkg: phase-code decode tables and helpers shared by the stepper drive and feedback sides.
package stepper_phase_pkg;

    localparam int SEQ_LEN = 16;
    localparam logic [1:0] MOD_IDX_LSB = 2'b10;

    typedef enum logic {INIT, TRACK} track_state_t;

    typedef struct packed {
        logic       legal;
        logic [3:0] idx;
    } decode_t;

    // Code bit order {p1I0, p1I1, p1ph, p2I0, p2I1, p2ph}; mask bit 0 marks a don't-care.
    localparam logic [5:0] DEC_MASK [SEQ_LEN] = '{
        6'b110111, 6'b111111, 6'b011011, 6'b111111,
        6'b111110, 6'b111111, 6'b011011, 6'b111111,
        6'b110111, 6'b111111, 6'b011011, 6'b111111,
        6'b111110, 6'b111111, 6'b011011, 6'b111111
    };
    localparam logic [5:0] DEC_VAL [SEQ_LEN] = '{
        6'b110001, 6'b011001, 6'b001001, 6'b001011,
        6'b001110, 6'b001010, 6'b001000, 6'b011000,
        6'b110000, 6'b010000, 6'b000000, 6'b000010,
        6'b000110, 6'b000011, 6'b000001, 6'b010001
    };

    function automatic decode_t phase_decode(input logic [5:0] code, input logic modified);
        decode_t r;
        r = '0;
        for (int i = SEQ_LEN - 1; i >= 0; i--) begin
            if ((code & DEC_MASK[i]) == DEC_VAL[i]) begin
                r.legal = 1'b1;
                r.idx   = 4'(i);
            end
        end
        if (r.legal && r.idx[1:0] == MOD_IDX_LSB)
            r.legal = (code[5] == modified) && (code[2] == modified);
        return r;
    endfunction

    function automatic logic [3:0] microstep_k(input logic [3:0] microstep);
        return microstep == 4'd1 ? 4'd4 : microstep == 4'd2 ? 4'd2 : 4'd1;
    endfunction

endpackage

// File: rtl/phase_input_filter.sv
// phase_input_filter: synchronizes the phase lines and accepts a code once it has held steady.
module phase_input_filter #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] raw,
    output logic [5:0] vec,
    output logic       accept
);
    localparam int CW = $clog2(STABLE_CYCLES + 2);

    logic [5:0]    sync_q [SYNC_STAGES];
    logic [5:0]    sync_d [SYNC_STAGES];
    logic [5:0]    hist_q, hist_d, vec_q, vec_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept_q, accept_d, same;

    always_comb begin
        sync_d[0] = raw;
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
        hist_d   = sync_q[SYNC_STAGES-1];
        same     = sync_q[SYNC_STAGES-1] == hist_q;
        // Count saturates one past the threshold so a held code strobes only once.
        cnt_d    = !same ? CW'(1) : cnt_q > CW'(STABLE_CYCLES) ? cnt_q : cnt_q + 1'b1;
        accept_d = cnt_q == CW'(STABLE_CYCLES);
        vec_d    = accept_d ? hist_q : vec_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '{default: '0};
            hist_q   <= '0;
            cnt_q    <= '0;
            vec_q    <= '0;
            accept_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            hist_q   <= hist_d;
            cnt_q    <= cnt_d;
            vec_q    <= vec_d;
            accept_q <= accept_d;
        end
    end

    assign vec    = vec_q;
    assign accept = accept_q;
endmodule

// File: rtl/stepper_phase_decoder.sv
// stepper_phase_decoder: reconstructs step events, direction and position from A3988 phase-drive lines.
module stepper_phase_decoder
    import stepper_phase_pkg::*;
#(
    parameter int POS_WIDTH     = 32,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 phase1_I0,
    input  logic                 phase1_I1,
    input  logic                 phase1_phase,
    input  logic                 phase2_I0,
    input  logic                 phase2_I1,
    input  logic                 phase2_phase,
    input  logic                 modified_mode,
    input  logic [3:0]           microstep,
    input  logic                 clear_pos,
    input  logic                 err_clear,
    output logic [3:0]           seq_index,
    output logic                 seq_valid,
    output logic                 step_pulse,
    output logic                 step_dir,
    output logic [POS_WIDTH-1:0] position,
    output logic                 err_illegal,
    output logic                 err_skip
);
    logic [5:0]           acc_vec;
    logic                 accept;
    decode_t              dec;
    logic [3:0]           k, delta;
    track_state_t         state_q, state_d;
    logic [3:0]           idx_q, idx_d;
    logic                 valid_q, valid_d, pulse_q, pulse_d, dir_q, dir_d;
    logic                 ill_q, ill_d, skip_q, skip_d;
    logic [POS_WIDTH-1:0] pos_q, pos_d;

    phase_input_filter #(.SYNC_STAGES(SYNC_STAGES), .STABLE_CYCLES(STABLE_CYCLES)) u_filter (
        .clk    (clk),
        .rst    (rst),
        .raw    ({phase1_I0, phase1_I1, phase1_phase, phase2_I0, phase2_I1, phase2_phase}),
        .vec    (acc_vec),
        .accept (accept)
    );

    assign dec   = phase_decode(acc_vec, modified_mode);
    assign k     = microstep_k(microstep);
    assign delta = dec.idx - idx_q;

    // seq_index doubles as the tracking reference; both always move together.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        pulse_d = 1'b0;
        dir_d   = dir_q;
        pos_d   = pos_q;
        ill_d   = ill_q & ~err_clear;
        skip_d  = skip_q & ~err_clear;
        if (accept) begin
            if (!dec.legal) begin
                ill_d   = 1'b1;
                valid_d = 1'b0;
            end else if (state_q == INIT) begin
                state_d = TRACK;
                idx_d   = dec.idx;
                valid_d = 1'b1;
            end else begin
                idx_d   = dec.idx;
                valid_d = 1'b1;
                if (delta == k) begin
                    pulse_d = 1'b1;
                    dir_d   = 1'b1;
                    pos_d   = pos_q + POS_WIDTH'(k);
                end else if (delta == 4'd0 - k) begin
                    pulse_d = 1'b1;
                    dir_d   = 1'b0;
                    pos_d   = pos_q - POS_WIDTH'(k);
                end else if (delta != 4'd0) begin
                    skip_d  = 1'b1;
                end
            end
        end
        if (clear_pos) pos_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            idx_q   <= '0;
            valid_q <= 1'b0;
            pulse_q <= 1'b0;
            dir_q   <= 1'b0;
            pos_q   <= '0;
            ill_q   <= 1'b0;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            pulse_q <= pulse_d;
            dir_q   <= dir_d;
            pos_q   <= pos_d;
            ill_q   <= ill_d;
            skip_q  <= skip_d;
        end
    end

    assign seq_index   = idx_q;
    assign seq_valid   = valid_q;
    assign step_pulse  = pulse_q;
    assign step_dir    = dir_q;
    assign position    = pos_q;
    assign err_illegal = ill_q;
    assign err_skip    = skip_q;
endmodule

// File: tb/tb_stepper_phase_decoder.sv
// tb_stepper_phase_decoder: table-driven scoreboard bench for stepper_phase_decoder.
module tb_stepper_phase_decoder;

    typedef struct {
        logic [5:0]  code;
        logic [3:0]  ms;
        logic        clr, cp;
        logic [3:0]  idx;
        logic        valid, pulse, dir;
        logic [31:0] pos;
        logic        ill, skip;
    } vec_t;

    typedef struct {
        int   due;
        int   tag;
        vec_t v;
    } exp_t;

    logic        clk = 1'b0, rst = 1'b1, mm = 1'b0, clear_pos = 1'b0, err_clear = 1'b0;
    logic [5:0]  code = '0;
    logic [3:0]  microstep = 4'd4;
    logic [3:0]  seq_index;
    logic        seq_valid, step_pulse, step_dir, err_illegal, err_skip;
    logic [31:0] position;

    int   cyc = 0, n_cmp = 0, n_bad = 0;
    int   p1, p2;
    exp_t sb[$];
    vec_t vecs[$];
    vec_t last, zero_v;

    // Codes for each sequence index with modified_mode = 0.
    logic [5:0] code_tab [16] = '{
        6'b110001, 6'b011001, 6'b001001, 6'b001011,
        6'b001110, 6'b001010, 6'b001000, 6'b011000,
        6'b110000, 6'b010000, 6'b000000, 6'b000010,
        6'b000110, 6'b000011, 6'b000001, 6'b010001
    };

    stepper_phase_decoder dut (
        .clk           (clk),
        .rst           (rst),
        .phase1_I0     (code[5]),
        .phase1_I1     (code[4]),
        .phase1_phase  (code[3]),
        .phase2_I0     (code[2]),
        .phase2_I1     (code[1]),
        .phase2_phase  (code[0]),
        .modified_mode (mm),
        .microstep     (microstep),
        .clear_pos     (clear_pos),
        .err_clear     (err_clear),
        .seq_index     (seq_index),
        .seq_valid     (seq_valid),
        .step_pulse    (step_pulse),
        .step_dir      (step_dir),
        .position      (position),
        .err_illegal   (err_illegal),
        .err_skip      (err_skip)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic vec_t mk(input logic [5:0] c, input int ms, input int clr, input int cp,
                                input int idx, input int valid, input int pulse, input int dir,
                                input int pos, input int ill, input int skip);
        vec_t v;
        v.code  = c;
        v.ms    = 4'(ms);
        v.clr   = clr != 0;
        v.cp    = cp != 0;
        v.idx   = 4'(idx);
        v.valid = valid != 0;
        v.pulse = pulse != 0;
        v.dir   = dir != 0;
        v.pos   = 32'(pos);
        v.ill   = ill != 0;
        v.skip  = skip != 0;
        return v;
    endfunction

    task automatic push(input int due, input int tag, input vec_t v, input logic pulse);
        exp_t e;
        e.due     = due;
        e.tag     = tag;
        e.v       = v;
        e.v.pulse = pulse;
        sb.push_back(e);
    endtask

    task automatic check(input exp_t e);
        logic [40:0] got, want;
        got  = {seq_index, seq_valid, step_pulse, step_dir, position, err_illegal, err_skip};
        want = {e.v.idx, e.v.valid, e.v.pulse, e.v.dir, e.v.pos, e.v.ill, e.v.skip};
        n_cmp++;
        if (e.due != cyc || got !== want) begin
            n_bad++;
            $display("FAIL chk%0d cyc=%0d due=%0d: got idx=%0d valid=%0b pulse=%0b dir=%0b pos=%0h ill=%0b skip=%0b, want idx=%0d valid=%0b pulse=%0b dir=%0b pos=%0h ill=%0b skip=%0b",
                     e.tag, cyc, e.due, seq_index, seq_valid, step_pulse, step_dir, position, err_illegal, err_skip,
                     e.v.idx, e.v.valid, e.v.pulse, e.v.dir, e.v.pos, e.v.ill, e.v.skip);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Each vector: previous outputs still held one cycle before the 6-edge latency,
    // new outputs at the latency edge, and step_pulse dropped again one cycle later.
    task automatic run_table(input int lo, input int hi);
        vec_t v;
        for (int i = lo; i < hi; i++) begin
            v         = vecs[i];
            code      = v.code;
            microstep = v.ms;
            push(cyc + 6, 1000 + i, last, 1'b0);
            push(cyc + 7, i, v, v.pulse);
            if (v.pulse) push(cyc + 8, 500 + i, v, 1'b0);
            for (int c = 1; c <= 8; c++) begin
                @(posedge clk);
                #1;
                err_clear = v.clr && c == 6;
                clear_pos = v.cp && c == 6;
            end
            last = v;
        end
    endtask

    initial begin
        zero_v = mk(6'b0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        last   = zero_v;
        vecs.push_back(mk(code_tab[1], 4, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        for (int j = 1; j <= 16; j++)
            vecs.push_back(mk(code_tab[(1 + j) % 16], 4, 0, 0, (1 + j) % 16, 1, 1, 1, j, 0, 0));
        for (int j = 1; j <= 16; j++)
            vecs.push_back(mk(code_tab[(17 - j) % 16], 4, 0, 0, (17 - j) % 16, 1, 1, 0, 16 - j, 0, 0));
        vecs.push_back(mk(code_tab[2],  4, 0, 0, 2,  1, 1, 1, 1,  0, 0));
        vecs.push_back(mk(code_tab[3],  4, 0, 0, 3,  1, 1, 1, 2,  0, 0));
        vecs.push_back(mk(code_tab[7],  1, 0, 0, 7,  1, 1, 1, 6,  0, 0));
        vecs.push_back(mk(code_tab[11], 1, 0, 0, 11, 1, 1, 1, 10, 0, 0));
        vecs.push_back(mk(code_tab[15], 1, 0, 0, 15, 1, 1, 1, 14, 0, 0));
        vecs.push_back(mk(code_tab[3],  1, 0, 0, 3,  1, 1, 1, 18, 0, 0));
        vecs.push_back(mk(code_tab[15], 1, 0, 0, 15, 1, 1, 0, 14, 0, 0));
        vecs.push_back(mk(code_tab[1],  2, 0, 0, 1,  1, 1, 1, 16, 0, 0));
        vecs.push_back(mk(code_tab[5],  2, 0, 0, 5,  1, 0, 1, 16, 0, 1));
        vecs.push_back(mk(code_tab[7],  2, 0, 0, 7,  1, 1, 1, 18, 0, 1));
        vecs.push_back(mk(6'b111111,    2, 0, 0, 7,  0, 0, 1, 18, 1, 1));
        vecs.push_back(mk(code_tab[7],  2, 1, 0, 7,  1, 0, 1, 18, 0, 0));
        vecs.push_back(mk(6'b101101,    2, 1, 0, 7,  0, 0, 1, 18, 1, 0));
        vecs.push_back(mk(code_tab[7],  2, 0, 0, 7,  1, 0, 1, 18, 1, 0));
        p1 = vecs.size();
        vecs.push_back(mk(code_tab[9],  2, 0, 1, 9,  1, 1, 1, 0,  1, 0));
        vecs.push_back(mk(code_tab[11], 2, 0, 0, 11, 1, 1, 1, 2,  1, 0));
        p2 = vecs.size();
        vecs.push_back(mk(code_tab[13], 2, 0, 0, 13, 1, 0, 0, 0,  0, 0));
        vecs.push_back(mk(code_tab[11], 2, 0, 0, 11, 1, 1, 0, -2, 0, 0));
        vecs.push_back(mk(code_tab[12], 7, 0, 0, 12, 1, 1, 1, -1, 0, 0));
        vecs.push_back(mk(code_tab[11], 0, 0, 0, 11, 1, 1, 0, -2, 0, 0));

        fork
            forever begin
                @(negedge clk);
                while (sb.size() > 0 && sb[0].due <= cyc) check(sb.pop_front());
            end
        join_none

        code      = code_tab[1];
        microstep = 4'd4;
        @(posedge clk);
        #1;
        push(cyc + 1, 3000, zero_v, 1'b0);
        push(cyc + 2, 3001, zero_v, 1'b0);
        hold(3);
        rst = 1'b0;
        run_table(0, p1);

        // Two-cycle glitch toward a one-step neighbour must leave every output untouched.
        code = code_tab[9];
        for (int c = 1; c <= 14; c++) push(cyc + c, 2000 + c, last, 1'b0);
        hold(2);
        code = code_tab[7];
        hold(14);

        run_table(p1, p2);

        // Reset while a new code is still inside the filter; the code afterwards loads as a first code.
        code = code_tab[13];
        hold(3);
        rst = 1'b1;
        push(cyc + 1, 3002, zero_v, 1'b0);
        push(cyc + 2, 3003, zero_v, 1'b0);
        hold(2);
        rst  = 1'b0;
        last = zero_v;
        run_table(p2, vecs.size());

        hold(3);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: pending=%0d, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/stepper_phase_decoder.md
# stepper_phase_decoder

Observes the six A3988 phase-drive lines produced by a StepperChannel and reconstructs the motion they command. It synchronizes and glitch-filters the lines, then decodes them to the 16-entry sequence index. It also emits a one-cycle step event with direction, accumulates a signed position in quarter-step units, and flags illegal codes and skipped steps. It sits on the feedback side of the PID processor, as closed-loop verification of each channel's drive output.

## Interface
- POS_WIDTH, 32: width of the position accumulator (two's complement).
- SYNC_STAGES, 2: flip-flop synchronizer depth on the phase inputs (≥2).
- STABLE_CYCLES, 3: consecutive identical synchronized samples required before a code is accepted (≥1).

- clk  in  1  system clock; one clock domain, all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- phase1_I0, phase1_I1, phase1_phase  in  1 each  phase-1 drive lines (asynchronous).
- phase2_I0, phase2_I1, phase2_phase  in  1 each  phase-2 drive lines (asynchronous).
- modified_mode  in  1  1 = modified sequence in use; indices 2/6/10/14 must have both I0 = 1.
- microstep  in  4  1, 2 or 4; any other value is treated as 4.
- clear_pos  in  1  zeroes position.
- err_clear  in  1  clears both sticky error flags.
- seq_index  out  4  last accepted legal index.
- seq_valid  out  1  last accepted code was legal.
- step_pulse  out  1  one-cycle step event.
- step_dir  out  1  direction of the last step; 1 = index increasing.
- position  out  POS_WIDTH  signed accumulated position in quarter-steps.
- err_illegal  out  1  sticky; an undecodable code was accepted.
- err_skip  out  1  sticky; a transition of the wrong magnitude was seen.

## Operation
- Decode is applied to {p1I0, p1I1, p1ph, p2I0, p2I1, p2ph}. x means don't-care, and the first match in index order wins.
  - Indices 0–7: 0=11x001, 1=011001, 2=x01x01, 3=001011, 4=00111x, 5=001010, 6=x01x00, 7=011000.
  - Indices 8–15: 8=11x000, 9=010000, 10=x00x00, 11=000010, 12=00011x, 13=000011, 14=x00x01, 15=010001.
  - Indices 2/6/10/14 are legal only if p1I0 == p2I0 == modified_mode.
  - Everything else is illegal.
- Step size k = 4 / 2 / 1 for microstep = 1 / 2 / 4.
- delta = (new − ref) mod 16, where ref is the reference index.
- FSM states:
  - INIT: no reference yet.
  - TRACK: reference held.
- INIT behaviour:
  - First accepted legal code loads ref and seq_index, sets seq_valid = 1, moves to TRACK, no step.
  - An illegal code sets err_illegal and stays in INIT.
- TRACK behaviour, per accepted code:
  - Illegal code: err_illegal = 1, seq_valid = 0; ref and seq_index held.
  - delta = 0: no action. This includes return from illegal to the same index; seq_valid returns to 1.
  - delta = k: step_pulse, step_dir = 1, position += k, ref = new.
  - delta = 16 − k: step_pulse, step_dir = 0, position −= k, ref = new.
  - Any other delta: err_skip = 1, no pulse, position unchanged, ref resyncs to new.
- Position wraps modulo 2^POS_WIDTH; there is no saturation.
- A microstep change takes effect on the next accepted code.

## Timing
- Reset values:
  - seq_index = 0, seq_valid = 0, step_pulse = 0, step_dir = 0.
  - position = 0, err_illegal = 0, err_skip = 0.
  - FSM in INIT; synchronizer and filter cleared, with the stability count at 0.
- Acceptance: a code is accepted once the synchronized vector has held the same value for STABLE_CYCLES consecutive samples. A code is accepted once per change; it is not re-accepted while held.
- Latency: new input value sampled at edge 0 → outputs update at edge SYNC_STAGES + STABLE_CYCLES + 1. This is 6 with the defaults.
- step_pulse is high exactly one cycle per accepted step. A change shorter than STABLE_CYCLES is ignored.
- clear_pos together with a step in the same cycle: position = 0. clear wins, but step_pulse and step_dir still update.
- err_clear together with a new error in the same cycle: the flag ends at 1.
- rst mid-operation: all state returns to reset values on that edge. The code present afterwards is treated as a first code (INIT).

## Structure
- Package stepper_phase_pkg, shared with StepperChannel:
  - decode function (6-bit code + modified_mode → legal, index);
  - index constants;
  - microstep-to-k function.
- Sub-module phase_input_filter: SYNC_STAGES synchronizer plus STABLE_CYCLES stability counter. It outputs the accepted 6-bit vector and a one-cycle accept strobe.
- Top level: decode, INIT/TRACK FSM, position accumulator, error flags.

## Test plan
- Reset, hold 011001 → seq_index = 1, seq_valid = 1 at edge 6; no step_pulse; position = 0.
- microstep = 4: walk indices 1→2→…→15→0→1, each held 8 cycles → 16 pulses with step_dir = 1, position = +16; reversed walk → position back to 0.
- microstep = 1: step 3→7→11→15→3 → 4 pulses, position = +16; then 3→15 (reverse) → step_dir = 0, position = +12.
- microstep = 2: jump 1→5 → err_skip = 1, no pulse, seq_index = 5; then 5→7 → normal step, position += 2; err_clear → err_skip = 0.
- Hold 111111 → err_illegal = 1, seq_valid = 0. With modified_mode = 0, drive 101101 (index 2 with I0 high) → err_illegal = 1.
- 2-cycle glitch to a neighbouring code → no pulse. clear_pos coincident with a step → position = 0 and step_pulse = 1. rst mid-walk → all outputs 0, FSM in INIT.
